// File: rtl/fp_vector_checker.sv
// Table-driven regression sequencer that replays stored vectors against the IEEE-754 ALU.
// Define FPVC_FLAG_CHECK_EN to also require alu_flags to match the stored expected flags.
module fp_vector_checker #(
  parameter int NUM_VECTORS    = 16,
  parameter int VEC_AW         = $clog2(NUM_VECTORS),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [VEC_AW-1:0] load_addr,
  input  logic [31:0]       load_a,
  input  logic [31:0]       load_b,
  input  logic [2:0]        load_op,
  input  logic              load_mode,
  input  logic              load_round,
  input  logic [31:0]       load_exp_result,
  input  logic [4:0]        load_exp_flags,
  input  logic              run,
  input  logic [VEC_AW:0]   run_count,
  output logic [31:0]       alu_op_a,
  output logic [31:0]       alu_op_b,
  output logic [2:0]        alu_op_code,
  output logic              alu_mode_fp,
  output logic              alu_round_mode,
  output logic              alu_start,
  input  logic [31:0]       alu_result,
  input  logic              alu_valid_out,
  input  logic [4:0]        alu_flags,
  output logic              busy,
  output logic              done,
  output logic [VEC_AW:0]   pass_count,
  output logic [VEC_AW:0]   fail_count,
  output logic [VEC_AW-1:0] first_fail_idx,
  output logic              first_fail_valid,
  output logic              timeout_err
);
  localparam int CW = VEC_AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] NUM_V  = CW'(NUM_VECTORS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_VALID, WAIT_CLEAR, DONE} state_t;

  state_t            state_q, state_d;
  logic [VEC_AW-1:0] idx_q, idx_d, firstFailIdx_q, firstFailIdx_d;
  logic [CW-1:0]     count_q, count_d, passCount_q, passCount_d, failCount_q, failCount_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              firstFailValid_q, firstFailValid_d, timeoutErr_q, timeoutErr_d;
  logic [31:0]       opA_q, opB_q;
  logic [2:0]        opCode_q;
  logic              modeFp_q, roundMode_q;
  logic              tableWe, resultMatch, vecPass, recordFail;

  logic [31:0] tblA     [NUM_VECTORS];
  logic [31:0] tblB     [NUM_VECTORS];
  logic [2:0]  tblOp    [NUM_VECTORS];
  logic        tblMode  [NUM_VECTORS];
  logic        tblRound [NUM_VECTORS];
  logic [31:0] tblExp   [NUM_VECTORS];
`ifdef FPVC_FLAG_CHECK_EN
  logic [4:0]  tblFlags [NUM_VECTORS];
`endif

  // The table has no reset so stored vectors survive a reset between sweeps.
  assign tableWe = load_we && (state_q == IDLE) && (32'(load_addr) < NUM_VECTORS);

  always_ff @(posedge clk) begin
    if (tableWe) begin
      tblA[load_addr]     <= load_a;
      tblB[load_addr]     <= load_b;
      tblOp[load_addr]    <= load_op;
      tblMode[load_addr]  <= load_mode;
      tblRound[load_addr] <= load_round;
      tblExp[load_addr]   <= load_exp_result;
`ifdef FPVC_FLAG_CHECK_EN
      tblFlags[load_addr] <= load_exp_flags;
`endif
    end
  end

  assign resultMatch = modeFp_q ? (alu_result == tblExp[idx_q])
                                : (alu_result[15:0] == tblExp[idx_q][15:0]);
`ifdef FPVC_FLAG_CHECK_EN
  assign vecPass = resultMatch && (alu_flags == tblFlags[idx_q]);
`else
  logic [4:0] unusedFlags;
  assign unusedFlags = load_exp_flags ^ alu_flags;
  assign vecPass     = resultMatch;
`endif

  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    count_d          = count_q;
    timer_d          = timer_q;
    passCount_d      = passCount_q;
    failCount_d      = failCount_q;
    firstFailIdx_d   = firstFailIdx_q;
    firstFailValid_d = firstFailValid_q;
    timeoutErr_d     = timeoutErr_q;
    recordFail       = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          passCount_d      = '0;
          failCount_d      = '0;
          firstFailIdx_d   = '0;
          firstFailValid_d = 1'b0;
          timeoutErr_d     = 1'b0;
          idx_d            = '0;
          if (run_count == '0) begin
            state_d = DONE;
          end else begin
            count_d = (run_count > NUM_V) ? NUM_V : run_count;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT_VALID;
      end
      WAIT_VALID: begin
        if (alu_valid_out) begin
          if (vecPass) passCount_d = passCount_q + CW'(1);
          else         recordFail  = 1'b1;
          timer_d = '0;
          state_d = WAIT_CLEAR;
        end else if (timer_q == T_LAST) begin
          timeoutErr_d = 1'b1;
          recordFail   = 1'b1;
          state_d      = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_CLEAR: begin
        if (!alu_valid_out) begin
          if ({1'b0, idx_q} == count_q - CW'(1)) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + VEC_AW'(1);
            state_d = ISSUE;
          end
        end else if (timer_q == T_LAST) begin
          timeoutErr_d = 1'b1;
          state_d      = DONE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Mismatches and WAIT_VALID timeouts share the same first-fail bookkeeping.
    if (recordFail) begin
      failCount_d = failCount_q + CW'(1);
      if (!firstFailValid_q) begin
        firstFailValid_d = 1'b1;
        firstFailIdx_d   = idx_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      count_q          <= '0;
      timer_q          <= '0;
      passCount_q      <= '0;
      failCount_q      <= '0;
      firstFailIdx_q   <= '0;
      firstFailValid_q <= 1'b0;
      timeoutErr_q     <= 1'b0;
      opA_q            <= '0;
      opB_q            <= '0;
      opCode_q         <= '0;
      modeFp_q         <= 1'b0;
      roundMode_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      count_q          <= count_d;
      timer_q          <= timer_d;
      passCount_q      <= passCount_d;
      failCount_q      <= failCount_d;
      firstFailIdx_q   <= firstFailIdx_d;
      firstFailValid_q <= firstFailValid_d;
      timeoutErr_q     <= timeoutErr_d;
      // Operands are captured on entry to ISSUE so they are already valid while alu_start is high.
      if (state_d == ISSUE) begin
        opA_q       <= tblA[idx_d];
        opB_q       <= tblB[idx_d];
        opCode_q    <= tblOp[idx_d];
        modeFp_q    <= tblMode[idx_d];
        roundMode_q <= tblRound[idx_d];
      end
    end
  end

  assign alu_op_a         = opA_q;
  assign alu_op_b         = opB_q;
  assign alu_op_code      = opCode_q;
  assign alu_mode_fp      = modeFp_q;
  assign alu_round_mode   = roundMode_q;
  assign alu_start        = (state_q == ISSUE) || (state_q == WAIT_VALID);
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);
  assign pass_count       = passCount_q;
  assign fail_count       = failCount_q;
  assign first_fail_idx   = firstFailIdx_q;
  assign first_fail_valid = firstFailValid_q;
  assign timeout_err      = timeoutErr_q;
endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed testbench for fp_vector_checker with a small latency-3 ALU response model.
`timescale 1ns/1ps
module tb_fp_vector_checker;
  localparam int NV = 16;
  localparam int AW = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_a = '0, load_b = '0, load_exp_result = '0;
  logic [2:0]    load_op = '0;
  logic          load_mode = 1'b0, load_round = 1'b0;
  logic [4:0]    load_exp_flags = '0;
  logic          run = 1'b0;
  logic [AW:0]   run_count = '0;
  logic [31:0]   alu_op_a, alu_op_b, alu_result;
  logic [2:0]    alu_op_code;
  logic          alu_mode_fp, alu_round_mode, alu_start, alu_valid_out;
  logic [4:0]    alu_flags;
  logic          busy, done, first_fail_valid, timeout_err;
  logic [AW:0]   pass_count, fail_count;
  logic [AW-1:0] first_fail_idx;

  int  vecCount = 0;
  int  missCount = 0;
  logic aluHang = 1'b0;
  int  aluCnt = 0;

  always #5 clk = ~clk;

  fp_vector_checker #(.NUM_VECTORS(NV), .VEC_AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_addr(load_addr), .load_a(load_a), .load_b(load_b),
    .load_op(load_op), .load_mode(load_mode), .load_round(load_round),
    .load_exp_result(load_exp_result), .load_exp_flags(load_exp_flags),
    .run(run), .run_count(run_count),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b), .alu_op_code(alu_op_code),
    .alu_mode_fp(alu_mode_fp), .alu_round_mode(alu_round_mode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_valid_out(alu_valid_out), .alu_flags(alu_flags),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
    .timeout_err(timeout_err)
  );

  // Known ALU answers for the directed vectors; anything else returns a ^ b with clean flags.
  function automatic logic [36:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic mode);
    if (a == 32'h40000000 && b == 32'h40000000 && op == 3'b000 && mode)  return {5'b00000, 32'h40800000};
    if (a == 32'h00004200 && b == 32'h00004000 && op == 3'b001 && !mode) return {5'b00000, 32'h00003C00};
    if (a == 32'h40000000 && b == 32'h00000000 && op == 3'b011 && mode)  return {5'b00000, 32'h7F800000};
    return {5'b00000, a ^ b};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      alu_valid_out <= 1'b0;
      alu_result    <= '0;
      alu_flags     <= '0;
      aluCnt        <= 0;
    end else if (!alu_start) begin
      alu_valid_out <= 1'b0;
      aluCnt        <= 0;
    end else if (!alu_valid_out && !aluHang) begin
      if (aluCnt == 2) begin
        alu_valid_out           <= 1'b1;
        {alu_flags, alu_result} <= aluRef(alu_op_a, alu_op_b, alu_op_code, alu_mode_fp);
        aluCnt                  <= 0;
      end else begin
        aluCnt <= aluCnt + 1;
      end
    end
  end

  task automatic loadEntry(input logic [AW-1:0] addr, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] op, input logic mode, input logic [31:0] expRes,
                           input logic [4:0] expFlg);
    @(negedge clk);
    load_we = 1'b1; load_addr = addr; load_a = a; load_b = b; load_op = op;
    load_mode = mode; load_exp_result = expRes; load_exp_flags = expFlg;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic startRun(input logic [AW:0] cnt);
    @(negedge clk);
    run = 1'b1; run_count = cnt;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int cycles, output bit seen);
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < budget) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); cycles++; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vecCount++; if (busy !== 1'b0) begin missCount++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vecCount++; if (done !== 1'b0) begin missCount++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    vecCount++; if (alu_start !== 1'b0) begin missCount++; $display("[TB] FAIL reset_start: got %b want 0", alu_start); end
    vecCount++; if ({pass_count, fail_count, first_fail_idx, first_fail_valid, timeout_err} !== '0) begin
      missCount++; $display("[TB] FAIL reset_counts: got p=%0d f=%0d idx=%0d v=%b t=%b want all 0",
                            pass_count, fail_count, first_fail_idx, first_fail_valid, timeout_err); end
    vecCount++; if ({alu_op_a, alu_op_b, alu_op_code, alu_mode_fp, alu_round_mode} !== '0) begin
      missCount++; $display("[TB] FAIL reset_operands: got a=%h b=%h want 0", alu_op_a, alu_op_b); end
    rst = 1'b0;
  endtask

  task automatic test_basic_sweep();
    int cyc; bit seen;
    loadEntry(4'd0, 32'h40000000, 32'h40000000, 3'b000, 1'b1, 32'h40800000, 5'b00000);
    loadEntry(4'd1, 32'h00004200, 32'h00004000, 3'b001, 1'b0, 32'h00003C00, 5'b00000);
    startRun(5'd2);
    vecCount++; if (alu_start !== 1'b1 || busy !== 1'b1) begin missCount++;
      $display("[TB] FAIL basic_start: got start=%b busy=%b want 1 1", alu_start, busy); end
    vecCount++; if (alu_op_a !== 32'h40000000 || alu_mode_fp !== 1'b1) begin missCount++;
      $display("[TB] FAIL basic_operand: got a=%h mode=%b want 40000000 1", alu_op_a, alu_mode_fp); end
    waitDone(100, cyc, seen);
    vecCount++; if (!seen) begin missCount++; $display("[TB] FAIL basic_done: got no done want done"); end
    vecCount++; if (pass_count !== 5'd2 || fail_count !== 5'd0 || first_fail_valid !== 1'b0) begin missCount++;
      $display("[TB] FAIL basic_counts: got p=%0d f=%0d v=%b want 2 0 0", pass_count, fail_count, first_fail_valid); end
    @(negedge clk);
    vecCount++; if (done !== 1'b0 || busy !== 1'b0) begin missCount++;
      $display("[TB] FAIL basic_single_pulse: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_result_mismatch();
    int cyc; bit seen;
    loadEntry(4'd1, 32'h00004200, 32'h00004000, 3'b001, 1'b0, 32'h00003E00, 5'b00000);
    startRun(5'd2);
    waitDone(100, cyc, seen);
    vecCount++; if (!seen || pass_count !== 5'd1 || fail_count !== 5'd1) begin missCount++;
      $display("[TB] FAIL mismatch_counts: got seen=%b p=%0d f=%0d want 1 1 1", seen, pass_count, fail_count); end
    vecCount++; if (first_fail_idx !== 4'd1 || first_fail_valid !== 1'b1) begin missCount++;
      $display("[TB] FAIL mismatch_first: got idx=%0d v=%b want 1 1", first_fail_idx, first_fail_valid); end
  endtask

  task automatic test_hp_mask();
    int cyc; bit seen;
    loadEntry(4'd1, 32'h00004200, 32'h00004000, 3'b001, 1'b0, 32'hFFFF3C00, 5'b00000);
    startRun(5'd2);
    waitDone(100, cyc, seen);
    vecCount++; if (!seen || pass_count !== 5'd2 || fail_count !== 5'd0) begin missCount++;
      $display("[TB] FAIL hp_mask: got seen=%b p=%0d f=%0d want 1 2 0", seen, pass_count, fail_count); end
  endtask

  task automatic test_flag_check();
    int cyc; bit seen;
    loadEntry(4'd2, 32'h40000000, 32'h00000000, 3'b011, 1'b1, 32'h7F800000, 5'b01000);
    startRun(5'd3);
    waitDone(150, cyc, seen);
`ifdef FPVC_FLAG_CHECK_EN
    vecCount++; if (!seen || pass_count !== 5'd2 || fail_count !== 5'd1 || first_fail_idx !== 4'd2) begin missCount++;
      $display("[TB] FAIL flag_check: got seen=%b p=%0d f=%0d idx=%0d want 1 2 1 2", seen, pass_count, fail_count, first_fail_idx); end
`else
    vecCount++; if (!seen || pass_count !== 5'd3 || fail_count !== 5'd0 || first_fail_valid !== 1'b0) begin missCount++;
      $display("[TB] FAIL flag_check: got seen=%b p=%0d f=%0d v=%b want 1 3 0 0", seen, pass_count, fail_count, first_fail_valid); end
`endif
  endtask

  task automatic test_timeout();
    int cyc; bit seen;
    aluHang = 1'b1;
    startRun(5'd1);
    vecCount++; if (alu_start !== 1'b1) begin missCount++; $display("[TB] FAIL timeout_start: got %b want 1", alu_start); end
    waitDone(40, cyc, seen);
    vecCount++; if (!seen || cyc < 16 || cyc > 17) begin missCount++;
      $display("[TB] FAIL timeout_latency: got seen=%b cycles=%0d want 16..17", seen, cyc); end
    vecCount++; if (timeout_err !== 1'b1 || fail_count !== 5'd1 || pass_count !== 5'd0) begin missCount++;
      $display("[TB] FAIL timeout_flags: got t=%b f=%0d p=%0d want 1 1 0", timeout_err, fail_count, pass_count); end
    vecCount++; if (first_fail_valid !== 1'b1 || first_fail_idx !== 4'd0 || alu_start !== 1'b0) begin missCount++;
      $display("[TB] FAIL timeout_first: got v=%b idx=%0d start=%b want 1 0 0", first_fail_valid, first_fail_idx, alu_start); end
    @(negedge clk);
    vecCount++; if (alu_start !== 1'b0 || done !== 1'b0) begin missCount++;
      $display("[TB] FAIL timeout_after: got start=%b done=%b want 0 0", alu_start, done); end
    aluHang = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc; bit seen; int doneSeen; bit reached;
    for (int i = 0; i < 8; i++)
      loadEntry(AW'(i), 32'(i) << 4, 32'(i) + 32'h100, 3'b010, 1'b1, 32'h100 + 32'(17 * i), 5'b00000);
    startRun(5'd8);
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      if (pass_count == 5'd3 && alu_start) reached = 1'b1;
    end
    vecCount++; if (!reached) begin missCount++; $display("[TB] FAIL midreset_reach: got no vector 3 issue want issue"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vecCount++; if ({busy, done, alu_start, timeout_err, first_fail_valid} !== 5'b0 || pass_count !== 5'd0 || alu_op_a !== 32'h0) begin
      missCount++; $display("[TB] FAIL midreset_outputs: got busy=%b start=%b p=%0d a=%h want 0", busy, alu_start, pass_count, alu_op_a); end
    rst = 1'b0;
    doneSeen = 0;
    repeat (30) begin @(negedge clk); if (done) doneSeen++; end
    vecCount++; if (doneSeen !== 0 || busy !== 1'b0) begin missCount++;
      $display("[TB] FAIL midreset_no_done: got pulses=%0d busy=%b want 0 0", doneSeen, busy); end
    startRun(5'd8);
    waitDone(300, cyc, seen);
    vecCount++; if (!seen || pass_count !== 5'd8 || fail_count !== 5'd0) begin missCount++;
      $display("[TB] FAIL midreset_rerun: got seen=%b p=%0d f=%0d want 1 8 0", seen, pass_count, fail_count); end
  endtask

  task automatic test_clamp();
    int cyc; bit seen;
    for (int i = 8; i < 16; i++)
      loadEntry(AW'(i), 32'(i) << 4, 32'(i) + 32'h100, 3'b010, 1'b1, 32'h100 + 32'(17 * i), 5'b00000);
    startRun(5'd31);
    waitDone(600, cyc, seen);
    vecCount++; if (!seen || pass_count !== 5'd16 || fail_count !== 5'd0) begin missCount++;
      $display("[TB] FAIL clamp: got seen=%b p=%0d f=%0d want 1 16 0", seen, pass_count, fail_count); end
  endtask

  task automatic test_guards();
    int cyc; bit seen; int busyCycles;
    loadEntry(4'd0, 32'h00000000, 32'h00000100, 3'b010, 1'b1, 32'h00000100, 5'b00000);
    startRun(5'd1);
    load_we = 1'b1; load_addr = 4'd0; load_exp_result = 32'h00000BAD;
    run = 1'b1; run_count = 5'd2;
    @(negedge clk);
    load_we = 1'b0; run = 1'b0;
    waitDone(100, cyc, seen);
    vecCount++; if (!seen || pass_count !== 5'd1 || fail_count !== 5'd0) begin missCount++;
      $display("[TB] FAIL guard_busy_write: got seen=%b p=%0d f=%0d want 1 1 0", seen, pass_count, fail_count); end
    busyCycles = 0;
    repeat (5) begin @(negedge clk); if (busy) busyCycles++; end
    vecCount++; if (busyCycles !== 0) begin missCount++;
      $display("[TB] FAIL guard_run_ignored: got busy cycles=%0d want 0", busyCycles); end
    startRun(5'd1);
    waitDone(100, cyc, seen);
    vecCount++; if (!seen || pass_count !== 5'd1 || fail_count !== 5'd0) begin missCount++;
      $display("[TB] FAIL guard_entry_kept: got seen=%b p=%0d f=%0d want 1 1 0", seen, pass_count, fail_count); end
    startRun(5'd0);
    vecCount++; if (done !== 1'b1 || pass_count !== 5'd0 || fail_count !== 5'd0 || first_fail_valid !== 1'b0) begin missCount++;
      $display("[TB] FAIL guard_zero_run: got done=%b p=%0d f=%0d v=%b want 1 0 0 0", done, pass_count, fail_count, first_fail_valid); end
    @(negedge clk);
    vecCount++; if (done !== 1'b0 || busy !== 1'b0) begin missCount++;
      $display("[TB] FAIL guard_zero_after: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_result_mismatch();
    test_hp_mask();
    test_flag_check();
    test_timeout();
    test_reset_mid_sweep();
    test_clamp();
    test_guards();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end
endmodule
